// File: rtl/niosii_ram_loader.sv
`default_nettype none
// niosii_ram_loader: packs a byte stream into 32-bit words, writes them to RAM, then optionally reads them back and verifies the sum.
// Rev 1.0
module niosii_ram_loader #(
  parameter int DEPTH  = 6400,
  parameter bit VERIFY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] base_addr,
  input  logic [12:0] word_count,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_fill  = 3'd1;
  localparam logic [2:0] c_write = 3'd2;
  localparam logic [2:0] c_vrd   = 3'd3;
  localparam logic [2:0] c_vcmp  = 3'd4;
  localparam logic [2:0] c_done  = 3'd5;
  localparam logic [13:0] c_depth = 14'(DEPTH);

  logic [2:0]  state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic [12:0] base_q, base_d;
  logic [12:0] count_q, count_d;
  logic [12:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] checksum_q, checksum_d;
  logic [31:0] vsum_q, vsum_d;
  logic        error_q, error_d;

  logic [13:0] w_range;
  logic        w_last;

  assign w_range = {1'b0, base_addr} + {1'b0, word_count};
  assign w_last  = (idx_q == count_q - 13'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    checksum_d = checksum_q;
    vsum_d     = vsum_q;
    error_d    = error_q;
    case (state_q)
      c_idle: begin
        if (start) begin
          // An empty load still counts as an accepted start.
          if (word_count == 13'd0) begin
            checksum_d = 32'd0;
            error_d    = 1'b0;
            state_d    = c_done;
          end else if (w_range > c_depth) begin
            error_d = 1'b1;
          end else begin
            base_d     = base_addr;
            addr_d     = base_addr;
            count_d    = word_count;
            idx_d      = 13'd0;
            byte_cnt_d = 2'd0;
            checksum_d = 32'd0;
            error_d    = 1'b0;
            state_d    = c_fill;
          end
        end
      end
      c_fill: begin
        if (in_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = c_write;
        end
      end
      c_write: begin
        checksum_d = checksum_q + word_q;
        if (w_last) begin
          if (VERIFY) begin
            addr_d  = base_q;
            idx_d   = 13'd0;
            vsum_d  = 32'd0;
            state_d = c_vrd;
          end else begin
            state_d = c_done;
          end
        end else begin
          addr_d  = addr_q + 13'd1;
          idx_d   = idx_q + 13'd1;
          state_d = c_fill;
        end
      end
      c_vrd: state_d = c_vcmp;
      c_vcmp: begin
        vsum_d = vsum_q + readdata;
        addr_d = addr_q + 13'd1;
        if (w_last) begin
          if (vsum_d != checksum_q) begin
            error_d = 1'b1;
            state_d = c_idle;
          end else begin
            state_d = c_done;
          end
        end else begin
          idx_d   = idx_q + 13'd1;
          state_d = c_vrd;
        end
      end
      c_done:  state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_idle;
      addr_q     <= 13'd0;
      base_q     <= 13'd0;
      count_q    <= 13'd0;
      idx_q      <= 13'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      checksum_q <= 32'd0;
      vsum_q     <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      error_q    <= error_d;
    end
  end

  assign in_ready   = (state_q == c_fill);
  assign chipselect = (state_q == c_write) || (state_q == c_vrd);
  assign write      = (state_q == c_write);
  assign address    = addr_q;
  assign byteenable = 4'hF;
  assign writedata  = word_q;
  assign busy       = (state_q != c_idle);
  assign done       = (state_q == c_done);
  assign error      = error_q;
  assign checksum   = checksum_q;

endmodule
`default_nettype wire
